battle_stat_updater: RTL and testbench

Sequential upstream stage for the HP/XP/level select muxes in front of the Pokémon stat register. On each attack it computes the defender's new HP with a saturating subtract, and pulses the HP select for one cycle. If the defender faints, it then computes the attacker's XP award and any level-up, and pulses the XP and level selects. All results are registered.

---
 rtl/pkmn_pkg.sv | 22 ++
 rtl/xp_award_calc.sv | 48 ++++
 rtl/battle_stat_updater.sv | 182 ++++++++++++++++++
 tb/tb_battle_stat_updater.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pkmn_pkg.sv
// -----------------------------------------------------------------------------
// pkmn_pkg
// Shared widths and FSM state type for the battle stat path. The HP/XP/level
// muxes in front of the stat register take their widths from here as well, so
// the updater and the muxes can never disagree on field sizes.
// -----------------------------------------------------------------------------
package pkmn_pkg;

  localparam int HP_W  = 6;
  localparam int XP_W  = 8;
  localparam int LVL_W = 4;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CALC_HP  = 3'd1,
    WRITE_HP = 3'd2,
    CALC_XP  = 3'd3,
    WRITE_XP = 3'd4,
    DONE     = 3'd5
  } battle_state_t;

endpackage

// File: rtl/xp_award_calc.sv
// -----------------------------------------------------------------------------
// xp_award_calc
// Purely combinational XP award / level-up calculation.
//   atk_xp    in  XP_W   attacker XP before the award
//   xp_gain   in  XP_W   XP awarded for the faint
//   atk_level in  LVL_W  attacker level before the award
//   xp_res    out XP_W   attacker XP after the award
//   lvl_up    out 1      one level is gained
// At most one level is granted per award; the leftover XP is clamped so the
// attacker never carries a full level's worth into the next level. At the
// level cap the XP simply accumulates and saturates at the field maximum.
// -----------------------------------------------------------------------------
module xp_award_calc
  import pkmn_pkg::*;
#(
  parameter int XP_PER_LEVEL = 100,
  parameter int MAX_LEVEL    = 15
) (
  input  logic [XP_W-1:0]  atk_xp,
  input  logic [XP_W-1:0]  xp_gain,
  input  logic [LVL_W-1:0] atk_level,
  output logic [XP_W-1:0]  xp_res,
  output logic             lvl_up
);

  // One extra bit so the raw sum never wraps.
  localparam logic [XP_W:0] XPL    = (XP_W+1)'(XP_PER_LEVEL);
  localparam logic [XP_W:0] XP_CAP = XPL - 1'b1;

  logic [XP_W:0] sum;
  logic [XP_W:0] over;
  logic          at_cap;

  always_comb begin
    sum    = {1'b0, atk_xp} + {1'b0, xp_gain};
    over   = sum - XPL;
    at_cap = (int'(atk_level) >= MAX_LEVEL);
    xp_res = sum[XP_W-1:0];
    lvl_up = 1'b0;
    if (at_cap) begin
      xp_res = sum[XP_W] ? {XP_W{1'b1}} : sum[XP_W-1:0];
    end else if (sum >= XPL) begin
      lvl_up = 1'b1;
      xp_res = (over > XP_CAP) ? XP_CAP[XP_W-1:0] : over[XP_W-1:0];
    end
  end

endmodule

// File: rtl/battle_stat_updater.sv
// -----------------------------------------------------------------------------
// battle_stat_updater
// Sequential stage feeding the HP/XP/level select muxes of the stat register.
// An attack request computes the defender's new HP (saturating at 0) and pulses
// hp_sel; if the defender faints, the attacker's XP award and possible level-up
// follow with an xp_sel / level_sel pulse.
//   Clk        in  1      clock, rising edge
//   Reset_n    in  1      synchronous active-low reset
//   start      in  1      one-cycle request
//   damage     in  HP_W   attack damage
//   def_hp     in  HP_W   defender HP
//   atk_xp     in  XP_W   attacker XP
//   atk_level  in  LVL_W  attacker level
//   xp_gain    in  XP_W   XP awarded on faint
//   hp_new     out HP_W   new defender HP (holds between operations)
//   hp_sel     out 1      one-cycle HP mux select
//   xp_new     out XP_W   new attacker XP (holds between operations)
//   xp_sel     out 1      one-cycle XP mux select
//   level_sel  out 1      one-cycle level mux select, only with xp_sel
//   busy       out 1      high in every state but IDLE
//   done       out 1      one-cycle completion pulse
//   fainted    out 1      faint flag, held until the next accepted start
//
// Handshake: start is a request with no acknowledge. It is accepted only on a
// rising edge where busy=0 (FSM in IDLE); while busy=1 it is dropped, not
// queued. The data inputs are captured on the accepting edge and not read
// again, so the caller may change them freely from the next cycle on.
// -----------------------------------------------------------------------------
module battle_stat_updater
  import pkmn_pkg::*;
#(
  parameter int XP_PER_LEVEL = 100,
  parameter int MAX_LEVEL    = 15
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             start,
  input  logic [HP_W-1:0]  damage,
  input  logic [HP_W-1:0]  def_hp,
  input  logic [XP_W-1:0]  atk_xp,
  input  logic [LVL_W-1:0] atk_level,
  input  logic [XP_W-1:0]  xp_gain,
  output logic [HP_W-1:0]  hp_new,
  output logic             hp_sel,
  output logic [XP_W-1:0]  xp_new,
  output logic             xp_sel,
  output logic             level_sel,
  output logic             busy,
  output logic             done,
  output logic             fainted
);

  battle_state_t    state_q;

  // Latched request operands.
  logic [HP_W-1:0]  damage_q;
  logic [HP_W-1:0]  def_hp_q;
  logic [XP_W-1:0]  atk_xp_q;
  logic [LVL_W-1:0] atk_level_q;
  logic [XP_W-1:0]  xp_gain_q;

  // Registered outputs.
  logic [HP_W-1:0]  hp_new_q;
  logic             hp_sel_q;
  logic [XP_W-1:0]  xp_new_q;
  logic             xp_sel_q;
  logic             level_sel_q;
  logic             busy_q;
  logic             done_q;
  logic             fainted_q;

  // Next-value combinational results.
  logic [HP_W-1:0]  hp_res_d;
  logic [XP_W-1:0]  xp_res_d;
  logic             lvl_up_d;

  // Saturating subtract: damage at or above current HP leaves 0, never wraps.
  always_comb begin
    hp_res_d = (damage_q >= def_hp_q) ? '0 : (def_hp_q - damage_q);
  end

  xp_award_calc #(
    .XP_PER_LEVEL (XP_PER_LEVEL),
    .MAX_LEVEL    (MAX_LEVEL)
  ) u_xp_award_calc (
    .atk_xp    (atk_xp_q),
    .xp_gain   (xp_gain_q),
    .atk_level (atk_level_q),
    .xp_res    (xp_res_d),
    .lvl_up    (lvl_up_d)
  );

  // Outputs are registered on the edge that enters each state, so a pulse is
  // visible for exactly the cycle the FSM spends in the matching state.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q     <= IDLE;
      damage_q    <= '0;
      def_hp_q    <= '0;
      atk_xp_q    <= '0;
      atk_level_q <= '0;
      xp_gain_q   <= '0;
      hp_new_q    <= '0;
      hp_sel_q    <= 1'b0;
      xp_new_q    <= '0;
      xp_sel_q    <= 1'b0;
      level_sel_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      fainted_q   <= 1'b0;
    end else begin
      hp_sel_q    <= 1'b0;
      xp_sel_q    <= 1'b0;
      level_sel_q <= 1'b0;
      done_q      <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            damage_q    <= damage;
            def_hp_q    <= def_hp;
            atk_xp_q    <= atk_xp;
            atk_level_q <= atk_level;
            xp_gain_q   <= xp_gain;
            fainted_q   <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= CALC_HP;
          end
        end
        CALC_HP: begin
          if (def_hp_q == '0) begin
            // Already fainted: no writes, so no second XP award.
            fainted_q <= 1'b1;
            done_q    <= 1'b1;
            state_q   <= DONE;
          end else begin
            hp_new_q  <= hp_res_d;
            hp_sel_q  <= 1'b1;
            fainted_q <= (hp_res_d == '0);
            state_q   <= WRITE_HP;
          end
        end
        WRITE_HP: begin
          // hp_new_q holds the result just written.
          if (hp_new_q == '0) begin
            state_q <= CALC_XP;
          end else begin
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        CALC_XP: begin
          xp_new_q    <= xp_res_d;
          xp_sel_q    <= 1'b1;
          level_sel_q <= lvl_up_d;
          state_q     <= WRITE_XP;
        end
        WRITE_XP: begin
          done_q  <= 1'b1;
          state_q <= DONE;
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign hp_new    = hp_new_q;
  assign hp_sel    = hp_sel_q;
  assign xp_new    = xp_new_q;
  assign xp_sel    = xp_sel_q;
  assign level_sel = level_sel_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign fainted   = fainted_q;

endmodule

// File: tb/tb_battle_stat_updater.sv
// -----------------------------------------------------------------------------
// tb_battle_stat_updater
// Cycle-by-cycle check of battle_stat_updater against a transaction-level model.
// Each accepted request expands into the expected output timeline (one entry
// per cycle); idle cycles expect held values and no pulses.
// -----------------------------------------------------------------------------
module tb_battle_stat_updater;

  localparam int XPL  = 100;
  localparam int MAXL = 15;

  // ---------------- clock / reset ----------------
  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic       Reset_n;
  logic       start;
  logic [5:0] damage;
  logic [5:0] def_hp;
  logic [7:0] atk_xp;
  logic [3:0] atk_level;
  logic [7:0] xp_gain;
  logic [5:0] hp_new;
  logic       hp_sel;
  logic [7:0] xp_new;
  logic       xp_sel;
  logic       level_sel;
  logic       busy;
  logic       done;
  logic       fainted;

  battle_stat_updater #(
    .XP_PER_LEVEL (XPL),
    .MAX_LEVEL    (MAXL)
  ) dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .start     (start),
    .damage    (damage),
    .def_hp    (def_hp),
    .atk_xp    (atk_xp),
    .atk_level (atk_level),
    .xp_gain   (xp_gain),
    .hp_new    (hp_new),
    .hp_sel    (hp_sel),
    .xp_new    (xp_new),
    .xp_sel    (xp_sel),
    .level_sel (level_sel),
    .busy      (busy),
    .done      (done),
    .fainted   (fainted)
  );

  // ---------------- model state / scoreboard ----------------
  // Vector layout: {hp_new, hp_sel, xp_new, xp_sel, level_sel, busy, done, fainted}
  logic [19:0] exp_q[$];
  logic [19:0] pending[$];
  int          checks = 0;
  int          errors = 0;
  logic [5:0]  m_hp    = '0;
  logic [7:0]  m_xp    = '0;
  logic        m_faint = 1'b0;
  logic        cur_busy = 1'b0;

  function automatic logic [19:0] mk(input logic [5:0] hp, input logic hs,
                                     input logic [7:0] xp, input logic xs,
                                     input logic ls, input logic b,
                                     input logic d, input logic f);
    return {hp, hs, xp, xs, ls, b, d, f};
  endfunction

  function automatic int hp_model(input int hp, input int dmg);
    return (dmg >= hp) ? 0 : hp - dmg;
  endfunction

  function automatic void xp_model(input int xp, input int gain, input int lvl,
                                   output int res, output logic up);
    int total;
    total = xp + gain;
    up    = 1'b0;
    if (lvl >= MAXL) begin
      res = (total > 255) ? 255 : total;
    end else if (total >= XPL) begin
      up  = 1'b1;
      res = total - XPL;
      if (res > XPL - 1) res = XPL - 1;
    end else begin
      res = total;
    end
  endfunction

  // Expand one accepted request into its per-cycle expected outputs.
  task automatic build_script(input int hp, input int dmg, input int xp,
                              input int gain, input int lvl);
    int   hr;
    int   xr;
    logic up;
    hr = hp_model(hp, dmg);
    m_faint = 1'b0;
    pending.push_back(mk(m_hp, 0, m_xp, 0, 0, 1, 0, 0));
    if (hp == 0) begin
      m_faint = 1'b1;
      pending.push_back(mk(m_hp, 0, m_xp, 0, 0, 1, 1, 1));
    end else begin
      m_hp    = 6'(hr);
      m_faint = (hr == 0);
      pending.push_back(mk(m_hp, 1, m_xp, 0, 0, 1, 0, m_faint));
      if (hr != 0) begin
        pending.push_back(mk(m_hp, 0, m_xp, 0, 0, 1, 1, 0));
      end else begin
        pending.push_back(mk(m_hp, 0, m_xp, 0, 0, 1, 0, 1));
        xp_model(xp, gain, lvl, xr, up);
        m_xp = 8'(xr);
        pending.push_back(mk(m_hp, 0, m_xp, 1, up, 1, 0, 1));
        pending.push_back(mk(m_hp, 0, m_xp, 0, 0, 1, 1, 1));
      end
    end
  endtask

  // ---------------- compare process ----------------
  initial begin
    logic [19:0] e;
    logic [19:0] got;
    forever begin
      @(posedge Clk);
      #2;
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        got = {hp_new, hp_sel, xp_new, xp_sel, level_sel, busy, done, fainted};
        checks++;
        if (got !== e) begin
          errors++;
          $display("FAIL outputs t=%0t got hp_new=%0d hp_sel=%b xp_new=%0d xp_sel=%b level_sel=%b busy=%b done=%b fainted=%b | exp hp_new=%0d hp_sel=%b xp_new=%0d xp_sel=%b level_sel=%b busy=%b done=%b fainted=%b",
                   $time, got[19:14], got[13], got[12:5], got[4], got[3], got[2], got[1], got[0],
                   e[19:14], e[13], e[12:5], e[4], e[3], e[2], e[1], e[0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a negedge: drive inputs for the coming edge and queue the
  // outputs expected just after it.
  task automatic cycle(input logic rn, input logic st, input logic [5:0] hp,
                       input logic [5:0] dmg, input logic [7:0] xp,
                       input logic [7:0] gain, input logic [3:0] lvl);
    logic [19:0] v;
    Reset_n   = rn;
    start     = st;
    def_hp    = hp;
    damage    = dmg;
    atk_xp    = xp;
    xp_gain   = gain;
    atk_level = lvl;
    if (!rn) begin
      pending.delete();
      m_hp = '0; m_xp = '0; m_faint = 1'b0;
      v = '0;
    end else begin
      if (st && !cur_busy) build_script(hp, dmg, xp, gain, lvl);
      if (pending.size() > 0) v = pending.pop_front();
      else                    v = mk(m_hp, 0, m_xp, 0, 0, 0, 0, m_faint);
    end
    cur_busy = v[2];
    exp_q.push_back(v);
    @(negedge Clk);
  endtask

  task automatic cycle_rand(input logic rn, input logic st);
    cycle(rn, st, 6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)),
          8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
          4'($urandom_range(0, 15)));
  endtask

  task automatic run_txn(input logic [5:0] hp, input logic [5:0] dmg,
                         input logic [7:0] xp, input logic [7:0] gain,
                         input logic [3:0] lvl);
    cycle(1'b1, 1'b1, hp, dmg, xp, gain, lvl);
    while (cur_busy) cycle_rand(1'b1, 1'b0);
  endtask

  task automatic pin(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int   r;
    logic u;
    int   hp_r;
    int   wait_cnt;
    Reset_n = 1'b0; start = 1'b0; damage = '0; def_hp = '0;
    atk_xp = '0; xp_gain = '0; atk_level = '0;
    @(negedge Clk);

    // Reset, including a start presented while in reset.
    cycle_rand(1'b0, 1'b0);
    cycle_rand(1'b0, 1'b0);
    cycle(1'b0, 1'b1, 6'd40, 6'd10, 8'd0, 8'd0, 4'd0);
    cycle_rand(1'b1, 1'b0);

    // Hand-computed values pinning the model itself.
    pin("hp_model_40_10", hp_model(40, 10), 30);
    pin("hp_model_20_25", hp_model(20, 25), 0);
    xp_model(50, 30, 3, r, u);   pin("xp_50_30", r, 80);  pin("lvl_50_30", int'(u), 0);
    xp_model(90, 30, 3, r, u);   pin("xp_90_30", r, 20);  pin("lvl_90_30", int'(u), 1);
    xp_model(99, 255, 2, r, u);  pin("xp_99_255", r, 99); pin("lvl_99_255", int'(u), 1);
    xp_model(240, 40, 15, r, u); pin("xp_cap", r, 255);   pin("lvl_cap", int'(u), 0);

    // Directed cases, back to back.
    run_txn(6'd40, 6'd10, 8'd0,   8'd0,   4'd0);
    run_txn(6'd20, 6'd25, 8'd50,  8'd30,  4'd3);
    run_txn(6'd5,  6'd5,  8'd90,  8'd30,  4'd3);
    run_txn(6'd7,  6'd63, 8'd99,  8'd255, 4'd2);
    run_txn(6'd1,  6'd1,  8'd240, 8'd40,  4'd15);
    run_txn(6'd33, 6'd0,  8'd10,  8'd10,  4'd1);

    // Defender already at 0 HP, with a second start while busy.
    cycle(1'b1, 1'b1, 6'd0, 6'd9, 8'd10, 8'd200, 4'd1);
    cycle(1'b1, 1'b1, 6'd30, 6'd40, 8'd60, 8'd60, 4'd1);
    while (cur_busy) cycle_rand(1'b1, 1'b0);
    cycle_rand(1'b1, 1'b0);

    // Reset on the edge starting cycle 3 of a faint sequence.
    cycle(1'b1, 1'b1, 6'd10, 6'd20, 8'd90, 8'd90, 4'd4);
    cycle_rand(1'b1, 1'b0);
    cycle_rand(1'b1, 1'b0);
    cycle_rand(1'b0, 1'b0);
    repeat (6) cycle_rand(1'b1, 1'b0);

    // Randomized traffic, faint-biased, with occasional resets.
    for (int i = 0; i < 600; i++) begin
      hp_r = $urandom_range(0, 63);
      if ($urandom_range(0, 1) == 1)
        cycle($urandom_range(0, 59) != 0, $urandom_range(0, 2) == 0,
              6'(hp_r), 6'($urandom_range(hp_r, 63)),
              8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
              ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom_range(0, 15)));
      else
        cycle_rand($urandom_range(0, 59) != 0, $urandom_range(0, 2) == 0);
    end
    repeat (8) cycle_rand(1'b1, 1'b0);

    wait_cnt = 0;
    while (exp_q.size() > 0 && wait_cnt < 20) begin
      @(negedge Clk);
      wait_cnt++;
    end
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain got %0d pending want 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
